// File: rtl/pixel_array_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_array_ctrl
// Sequences one image frame through a pixel array: erase, expose, ramp
// conversion with a broadcast 8-bit count, then row-by-row readout under
// ready/valid flow control. All outputs are registered.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   START       frame request, only looked at while idle
//   ROW_READY   downstream accepts the presented row (readout only)
//   ERASE       erase strobe, all rows
//   EXPOSE      expose strobe, all rows
//   RAMP        ramp/convert enable, all rows
//   COUNTER     conversion count, all rows
//   READ        one-hot row read enable
//   ROW_VALID   presented row is stable
//   ROW_INDEX   index of the presented row
//   BUSY        high whenever a frame is in progress
//   FRAME_DONE  one-cycle pulse when the last row has been accepted
// -----------------------------------------------------------------------------
module pixel_array_ctrl #(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int ERASE_CYCLES       = 5,
    parameter int EXPOSE_CYCLES      = 255,
    localparam int IDX_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          START,
    input  logic                          ROW_READY,
    output logic                          ERASE,
    output logic                          EXPOSE,
    output logic                          RAMP,
    output logic [7:0]                    COUNTER,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
    output logic                          ROW_VALID,
    output logic [IDX_W-1:0]              ROW_INDEX,
    output logic                          BUSY,
    output logic                          FRAME_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

    localparam logic [7:0]       ERASE_LAST_C  = 8'(ERASE_CYCLES);
    localparam logic [7:0]       EXPOSE_LAST_C = 8'(EXPOSE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_ROW_C    = IDX_W'(PIXEL_ARRAY_HEIGHT - 1);
    localparam logic [PIXEL_ARRAY_HEIGHT-1:0] FIRST_ROW_C = PIXEL_ARRAY_HEIGHT'(1);

    state_t                        state_r;
    // Cycles already spent in the current ERASE/EXPOSE phase, counting from 1.
    logic [7:0]                    phase_cnt_r;
    logic                          erase_r;
    logic                          expose_r;
    logic                          ramp_r;
    logic [7:0]                    counter_r;
    logic [PIXEL_ARRAY_HEIGHT-1:0] read_r;
    logic                          row_valid_r;
    logic [IDX_W-1:0]              row_index_r;
    logic                          busy_r;
    logic                          frame_done_r;

    // Frame sequencer: state and every output are updated together so the
    // outputs always describe the state that is current after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            phase_cnt_r  <= 8'd0;
            erase_r      <= 1'b0;
            expose_r     <= 1'b0;
            ramp_r       <= 1'b0;
            counter_r    <= 8'd0;
            read_r       <= '0;
            row_valid_r  <= 1'b0;
            row_index_r  <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r     <= ST_ERASE;
                        phase_cnt_r <= 8'd1;
                        erase_r     <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_ERASE: begin
                    if (phase_cnt_r == ERASE_LAST_C) begin
                        state_r     <= ST_EXPOSE;
                        phase_cnt_r <= 8'd1;
                        erase_r     <= 1'b0;
                        expose_r    <= 1'b1;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 8'd1;
                    end
                end
                ST_EXPOSE: begin
                    if (phase_cnt_r == EXPOSE_LAST_C) begin
                        state_r     <= ST_CONVERT;
                        phase_cnt_r <= 8'd0;
                        expose_r    <= 1'b0;
                        ramp_r      <= 1'b1;
                        counter_r   <= 8'd0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 8'd1;
                    end
                end
                ST_CONVERT: begin
                    // COUNTER stops at 255 and is held there through readout.
                    if (counter_r == 8'd255) begin
                        state_r     <= ST_READOUT;
                        ramp_r      <= 1'b0;
                        read_r      <= FIRST_ROW_C;
                        row_valid_r <= 1'b1;
                        row_index_r <= '0;
                    end else begin
                        counter_r <= counter_r + 8'd1;
                    end
                end
                ST_READOUT: begin
                    if (ROW_READY) begin
                        if (row_index_r == LAST_ROW_C) begin
                            state_r      <= ST_IDLE;
                            read_r       <= '0;
                            row_valid_r  <= 1'b0;
                            row_index_r  <= '0;
                            counter_r    <= 8'd0;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
                        end else begin
                            read_r      <= read_r << 1;
                            row_index_r <= row_index_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    phase_cnt_r  <= 8'd0;
                    erase_r      <= 1'b0;
                    expose_r     <= 1'b0;
                    ramp_r       <= 1'b0;
                    counter_r    <= 8'd0;
                    read_r       <= '0;
                    row_valid_r  <= 1'b0;
                    row_index_r  <= '0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign ERASE      = erase_r;
    assign EXPOSE     = expose_r;
    assign RAMP       = ramp_r;
    assign COUNTER    = counter_r;
    assign READ       = read_r;
    assign ROW_VALID  = row_valid_r;
    assign ROW_INDEX  = row_index_r;
    assign BUSY       = busy_r;
    assign FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_array_ctrl
// Self-checking bench for pixel_array_ctrl at default parameters. A frame
// model builds the expected per-cycle output trace (and the ROW_READY plan
// that goes with it) from phase lengths and stall counts; scenario tasks play
// the plan into the DUT and compare every cycle. A monitor checks the
// invariants (strobe exclusion, READ one-hot, FRAME_DONE width) throughout.
// -----------------------------------------------------------------------------
module tb_pixel_array_ctrl;

    localparam int H      = 2;
    localparam int IW     = 1;
    localparam int N_ER   = 5;
    localparam int N_EX   = 255;

    typedef struct packed {
        logic          erase;
        logic          expose;
        logic          ramp;
        logic [7:0]    counter;
        logic [H-1:0]  read;
        logic          valid;
        logic [IW-1:0] idx;
        logic          busy;
        logic          done;
    } obs_t;

    logic          clk;
    logic          reset;
    logic          START;
    logic          ROW_READY;
    logic          ERASE;
    logic          EXPOSE;
    logic          RAMP;
    logic [7:0]    COUNTER;
    logic [H-1:0]  READ;
    logic          ROW_VALID;
    logic [IW-1:0] ROW_INDEX;
    logic          BUSY;
    logic          FRAME_DONE;

    obs_t obs_s;
    assign obs_s = {ERASE, EXPOSE, RAMP, COUNTER, READ, ROW_VALID, ROW_INDEX, BUSY, FRAME_DONE};

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    bit   rdy_q[$];
    logic prev_done = 1'b0;

    pixel_array_ctrl #(
        .PIXEL_ARRAY_HEIGHT(H),
        .ERASE_CYCLES      (N_ER),
        .EXPOSE_CYCLES     (N_EX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .START     (START),
        .ROW_READY (ROW_READY),
        .ERASE     (ERASE),
        .EXPOSE    (EXPOSE),
        .RAMP      (RAMP),
        .COUNTER   (COUNTER),
        .READ      (READ),
        .ROW_VALID (ROW_VALID),
        .ROW_INDEX (ROW_INDEX),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariant monitor, sampled mid-cycle.
    always @(negedge clk) begin
        checks += 1;
        if ((int'(ERASE) + int'(EXPOSE) + int'(RAMP) + int'(ROW_VALID)) > 1) begin
            errors += 1;
            $display("FAIL excl t=%0t strobes=%b%b%b%b required at most one", $time, ERASE, EXPOSE, RAMP, ROW_VALID);
        end
        checks += 1;
        if ($countones(READ) > 1) begin
            errors += 1;
            $display("FAIL read_onehot t=%0t READ=%b required one-hot or zero", $time, READ);
        end
        checks += 1;
        if (prev_done && FRAME_DONE) begin
            errors += 1;
            $display("FAIL done_width t=%0t FRAME_DONE high two cycles required one", $time);
        end
        prev_done = FRAME_DONE;
    end

    // Append one frame to the expected trace. A stall value < 0 picks a random
    // stall in 0..smax. ROW_READY outside readout is random (must be ignored).
    task automatic model_frame(input int stall0, input int stall1, input int smax);
        obs_t o;
        int   s;
        for (int i = 0; i < N_ER; i++) begin
            o = '0; o.erase = 1'b1; o.busy = 1'b1;
            exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(1, 0)));
        end
        for (int i = 0; i < N_EX; i++) begin
            o = '0; o.expose = 1'b1; o.busy = 1'b1;
            exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(1, 0)));
        end
        for (int c = 0; c < 256; c++) begin
            o = '0; o.ramp = 1'b1; o.counter = 8'(c); o.busy = 1'b1;
            exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(1, 0)));
        end
        for (int r = 0; r < H; r++) begin
            s = (r == 0) ? stall0 : stall1;
            if (s < 0) s = int'($urandom_range(smax, 0));
            for (int k = 0; k <= s; k++) begin
                o = '0; o.counter = 8'd255; o.valid = 1'b1; o.idx = IW'(r);
                o.read[r] = 1'b1; o.busy = 1'b1;
                exp_q.push_back(o); rdy_q.push_back(k == s);
            end
        end
        o = '0; o.done = 1'b1;
        exp_q.push_back(o); rdy_q.push_back(1'($urandom_range(1, 0)));
    endtask

    task automatic test_reset();
        reset = 1'b1; START = 1'b1; ROW_READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks += 1;
        if (obs_s !== obs_t'(0)) begin
            errors += 1;
            $display("FAIL reset_state got=%h required=%h", obs_s, obs_t'(0));
        end
        // START present in the first cycle after release must be taken.
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        START = 1'b0;
        checks += 1;
        if (ERASE !== 1'b1 || BUSY !== 1'b1 || EXPOSE !== 1'b0) begin
            errors += 1;
            $display("FAIL start_after_reset ERASE=%b BUSY=%b required 1 1", ERASE, BUSY);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks += 1;
        if (obs_s !== obs_t'(0)) begin
            errors += 1;
            $display("FAIL reset_in_erase got=%h required=%h", obs_s, obs_t'(0));
        end
    endtask

    task automatic test_nominal();
        int done_at = 0;
        exp_q.delete(); rdy_q.delete();
        model_frame(0, 0, 0);
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            ROW_READY = rdy_q[i];
            @(negedge clk);
            checks += 1;
            if (obs_s !== exp_q[i]) begin
                errors += 1;
                $display("FAIL nominal cyc=%0d got=%h required=%h", i + 1, obs_s, exp_q[i]);
            end
            if (FRAME_DONE === 1'b1 && done_at == 0) done_at = i + 1;
            @(posedge clk); #1;
        end
        checks += 1;
        if (done_at != 519) begin
            errors += 1;
            $display("FAIL frame_length got=%0d required=519", done_at);
        end
    endtask

    task automatic test_start_during_frame();
        exp_q.delete(); rdy_q.delete();
        model_frame(-1, -1, 3);
        START = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            ROW_READY = rdy_q[i];
            START = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(1, 0));
            @(negedge clk);
            checks += 1;
            if (obs_s !== exp_q[i]) begin
                errors += 1;
                $display("FAIL start_ignored cyc=%0d got=%h required=%h", i + 1, obs_s, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        START = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_q.delete(); rdy_q.delete();
        model_frame(10, 0, 0);
        model_frame(-1, -1, 6);
        for (int f = 0; f < 2; f++) begin
            START = 1'b1;
            @(posedge clk); #1;
            START = 1'b0;
            while (exp_q.size() > 0) begin
                obs_t e;
                e = exp_q.pop_front();
                ROW_READY = rdy_q.pop_front();
                @(negedge clk);
                checks += 1;
                if (obs_s !== e) begin
                    errors += 1;
                    $display("FAIL backpressure f=%0d got=%h required=%h", f, obs_s, e);
                end
                @(posedge clk); #1;
                if (e.done) break;
            end
        end
    endtask

    task automatic test_reset_midframe();
        int cut;
        exp_q.delete(); rdy_q.delete();
        model_frame(0, 0, 0);
        cut = N_ER + N_EX + 100;
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        for (int i = 0; i <= cut; i++) begin
            ROW_READY = rdy_q[i];
            @(negedge clk);
            checks += 1;
            if (obs_s !== exp_q[i]) begin
                errors += 1;
                $display("FAIL pre_reset cyc=%0d got=%h required=%h", i + 1, obs_s, exp_q[i]);
            end
            if (i == cut) begin
                reset = 1'b1; START = 1'b1; ROW_READY = 1'b1;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; START = 1'b0;
        @(negedge clk);
        checks += 1;
        if (obs_s !== obs_t'(0)) begin
            errors += 1;
            $display("FAIL reset_midframe got=%h required=%h", obs_s, obs_t'(0));
        end
        @(posedge clk); #1;
        checks += 1;
        if (obs_s !== obs_t'(0)) begin
            errors += 1;
            $display("FAIL idle_after_reset got=%h required=%h", obs_s, obs_t'(0));
        end
        exp_q.delete(); rdy_q.delete();
        model_frame(0, 0, 0);
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            ROW_READY = rdy_q[i];
            @(negedge clk);
            checks += 1;
            if (obs_s !== exp_q[i]) begin
                errors += 1;
                $display("FAIL post_reset_frame cyc=%0d got=%h required=%h", i + 1, obs_s, exp_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete(); rdy_q.delete();
        for (int f = 0; f < 4; f++) model_frame(-1, -1, 2);
        START = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2000; i++) begin
            ROW_READY = rdy_q[i];
            @(negedge clk);
            checks += 1;
            if (obs_s !== exp_q[i]) begin
                errors += 1;
                $display("FAIL back_to_back cyc=%0d got=%h required=%h", i + 1, obs_s, exp_q[i]);
            end
            if (i > 0 && exp_q[i - 1].done) begin
                checks += 1;
                if (ERASE !== 1'b1) begin
                    errors += 1;
                    $display("FAIL restart_after_done cyc=%0d ERASE=%b required 1", i + 1, ERASE);
                end
            end
            @(posedge clk); #1;
        end
        START = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; START = 1'b0; ROW_READY = 1'b0;
        test_reset();
        test_nominal();
        test_start_during_frame();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
